program_loader: RTL and testbench

//  Drives the programming side of the memory address register and RAM.

---
 rtl/program_loader.sv | 139 +++++++++++++
 tb/tb_program_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams 2**ADDR_WIDTH words into RAM through the MAR programming bus, then releases run mode.
// Optional trailing-checksum verification is enabled with `define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr_bar,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] prog_bus_out,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_we,
  output logic                  run_not_prog,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] prog_bus_reg, prog_bus_next;
  logic [DATA_WIDTH-1:0] prog_data_reg, prog_data_next;
  logic [DATA_WIDTH-1:0] sum_reg, sum_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    prog_bus_next  = prog_bus_reg;
    prog_data_next = prog_data_reg;
    sum_next       = sum_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LOAD;
          addr_next  = '0;
          sum_next   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          prog_data_next = in_data;
          prog_bus_next  = addr_reg;
          sum_next       = sum_reg + in_data;
          state_next     = S_WRITE;
        end
      end
      S_WRITE: state_next = S_HOLD;
      S_HOLD: begin
        // The last address always ends the image; the counter never wraps.
        if (addr_reg == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
          done_next  = 1'b1;
`endif
        end else begin
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          state_next = S_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (in_valid) begin
          if (in_data == sum_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_ERROR;
            err_next   = 1'b1;
          end
        end
      end
      S_ERROR: begin
        if (start) begin
          state_next = S_LOAD;
          addr_next  = '0;
          sum_next   = '0;
          err_next   = 1'b0;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_bar) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      prog_bus_reg  <= '0;
      prog_data_reg <= '0;
      sum_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      prog_bus_reg  <= prog_bus_next;
      prog_data_reg <= prog_data_next;
      sum_reg       <= sum_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // ERROR keeps the MAR on the programming bus so a bad image never runs.
  assign run_not_prog = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign in_ready     = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign busy         = (state_reg == S_LOAD) || (state_reg == S_WRITE) ||
                        (state_reg == S_HOLD) || (state_reg == S_CHECK);
  assign prog_we      = (state_reg == S_WRITE);
  assign prog_bus_out = prog_bus_reg;
  assign prog_data    = prog_data_reg;
  assign done         = done_reg;
`ifdef LOADER_CHECKSUM_EN
  assign err          = err_reg;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, full load, stalls, ignored inputs, reload and
// (with LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_program_loader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          clr_bar = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] prog_bus_out;
  logic [DW-1:0] prog_data;
  logic          prog_we;
  logic          run_not_prog;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int exp_wr = 0;
  int idx = 0;
  int cyc = 0;
  logic [DW-1:0] ram [NW];

`ifdef LOADER_CHECKSUM_EN
  localparam int DONE_CYC = 50;
`else
  localparam int DONE_CYC = 49;
`endif

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .clr_bar(clr_bar), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .prog_bus_out(prog_bus_out),
    .prog_data(prog_data), .prog_we(prog_we), .run_not_prog(run_not_prog),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: every write must be in address order and only in programming mode.
  always @(negedge clk) begin
    if (prog_we) begin
      check("wr_addr", 32'(prog_bus_out), 32'(exp_wr[AW-1:0]));
      check("wr_mode", 32'(run_not_prog), 32'd0);
      ram[prog_bus_out] = prog_data;
      exp_wr++;
      wr_cnt++;
    end
  end

  task automatic step();
    logic hs;
    hs = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (hs) idx++;
  endtask

  task automatic run_load(input logic [7:0] base, input logic [7:0] chk,
                          input int stall_idx, input int start_idx, output int ncyc);
    int stall_cnt;
    stall_cnt = 0;
    idx = 0;
    exp_wr = 0;
    wr_cnt = 0;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rnp", 32'(run_not_prog), 32'd0);
    check("start_err", 32'(err), 32'd0);
    ncyc = 1;
    while (!done && !err && ncyc < 300) begin
      in_data  = (idx < NW) ? base + 8'(idx) : chk;
      in_valid = 1'b1;
      start    = (idx == start_idx);
      if (idx == stall_idx && in_ready && stall_cnt < 5) begin
        in_valid = 1'b0;
        stall_cnt++;
      end
      step();
      ncyc++;
      if (stall_cnt == 5) begin
        check("stall_ready", 32'(in_ready), 32'd1);
        check("stall_we", 32'(prog_we), 32'd0);
        check("stall_wrcnt", 32'(wr_cnt), 32'd3);
        check("stall_bus", 32'(prog_bus_out), 32'd2);
        stall_cnt = 6;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("load_timeout", 32'(done || err), 32'd1);
    $display("load base=%02h chk=%02h cycles=%0d writes=%0d done=%0b err=%0b",
             base, chk, ncyc, wr_cnt, done, err);
  endtask

  task automatic check_ram(input string tag, input logic [7:0] base);
    for (int i = 0; i < NW; i++) check(tag, 32'(ram[i]), 32'(base + 8'(i)));
    check({tag, "_cnt"}, 32'(wr_cnt), 32'd16);
  endtask

  initial begin
    // T1: reset state, then reset in the middle of a load
    repeat (2) step();
    check("rst_rnp", 32'(run_not_prog), 32'd1);
    check("rst_we", 32'(prog_we), 32'd0);
    check("rst_bus", 32'(prog_bus_out), 32'd0);
    check("rst_data", 32'(prog_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr_bar = 1'b1;
    idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(wr_cnt == 5 && in_ready) && cyc < 100) begin
      in_valid = 1'b1;
      in_data = 8'(idx);
      step();
      cyc++;
    end
    check("mid_wrcnt", 32'(wr_cnt), 32'd5);
    check("mid_bus", 32'(prog_bus_out), 32'd4);
    clr_bar = 1'b0;
    step();
    check("mrst_rnp", 32'(run_not_prog), 32'd1);
    check("mrst_we", 32'(prog_we), 32'd0);
    check("mrst_bus", 32'(prog_bus_out), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd0);
    clr_bar = 1'b1;
    in_valid = 1'b0;
    step();
    check("mrst_idle", 32'(busy), 32'd0);
    $display("reset mid-load at addr 5 checked");

    // T2: full back-to-back load
    run_load(8'h10, 8'h78, -1, -1, cyc);
    check("t2_done_cyc", 32'(cyc), 32'(DONE_CYC));
    check("t2_done", 32'(done), 32'd1);
    check("t2_rnp", 32'(run_not_prog), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_bus", 32'(prog_bus_out), 32'hF);
    check_ram("t2_ram", 8'h10);
    step();
    check("t2_done_pulse", 32'(done), 32'd0);
    check("t2_bus_hold", 32'(prog_bus_out), 32'hF);

    // T3/T4: stall at word 3, start held during word 7, then valid while DONE
    run_load(8'h20, 8'h78, 3, 7, cyc);
    check("t3_done", 32'(done), 32'd1);
    check_ram("t3_ram", 8'h20);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("t4_wrcnt", 32'(wr_cnt), 32'd16);
    check("t4_rnp", 32'(run_not_prog), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);

    // T6: reload from DONE; sum wraps to 0x78 for 0xA0..0xAF
    run_load(8'hA0, 8'h78, -1, -1, cyc);
    check("t6_done", 32'(done), 32'd1);
    check("t6_err", 32'(err), 32'd0);
    check_ram("t6_ram", 8'hA0);

`ifdef LOADER_CHECKSUM_EN
    // T5: checksum pass, fail, then start clears the error
    run_load(8'h01, 8'h88, -1, -1, cyc);
    check("t5_pass_done", 32'(done), 32'd1);
    check("t5_pass_err", 32'(err), 32'd0);
    run_load(8'h01, 8'h87, -1, -1, cyc);
    check("t5_fail_err", 32'(err), 32'd1);
    check("t5_fail_rnp", 32'(run_not_prog), 32'd0);
    check("t5_fail_busy", 32'(busy), 32'd0);
    check("t5_fail_ready", 32'(in_ready), 32'd0);
    check("t5_fail_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("t5_err_hold", 32'(err), 32'd1);
    check("t5_err_wrcnt", 32'(wr_cnt), 32'd16);
    run_load(8'h01, 8'h88, -1, -1, cyc);
    check("t5_clear_err", 32'(err), 32'd0);
    check("t5_clear_done", 32'(done), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
